// File: rtl/native_port_responder_pkg.sv
// Shared definitions for the native-port responder: default widths, command-queue entry layout
// and response-FIFO sizing.
package native_port_pkg;

  localparam int DEF_ADDR_W     = 24;
  localparam int DEF_DATA_W     = 256;
  localparam int DEF_DEPTH_LOG2 = 10;
  localparam int DEF_RD_LATENCY = 4;
  localparam int DEF_CMD_DEPTH  = 4;

  // Queued command; the address is already folded onto the backing-memory index range.
  typedef struct packed {
    logic                      we;
    logic [DEF_DEPTH_LOG2-1:0] addr;
  } cmd_entry_t;

  // Two extra slots beyond the pipeline depth keep reads streaming while the consumer accepts.
  function automatic int resp_depth(input int rd_latency);
    return rd_latency + 2;
  endfunction

endpackage

// File: rtl/native_port_responder_if.sv
// LiteDRAM user native port bundle (cmd / wdata / rdata); master = initiator, slave = responder.
interface native_port_responder_if
  import native_port_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_we;
  logic [ADDR_W-1:0]   cmd_addr;

  logic                wdata_valid;
  logic                wdata_ready;
  logic [DATA_W/8-1:0] wdata_we;
  logic [DATA_W-1:0]   wdata_data;

  logic                rdata_valid;
  logic                rdata_ready;
  logic [DATA_W-1:0]   rdata_data;

  modport master (
    output cmd_valid, cmd_we, cmd_addr,
    output wdata_valid, wdata_we, wdata_data,
    output rdata_ready,
    input  cmd_ready, wdata_ready, rdata_valid, rdata_data
  );

  modport slave (
    input  cmd_valid, cmd_we, cmd_addr,
    input  wdata_valid, wdata_we, wdata_data,
    input  rdata_ready,
    output cmd_ready, wdata_ready, rdata_valid, rdata_data
  );

endinterface

// File: rtl/native_port_responder_sync_fifo.sv
// Synchronous FIFO with occupancy count; DEPTH need not be a power of two.
module sync_fifo
  import native_port_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       user_clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = store[rd_ptr];
  assign do_pop   = pop && !empty;
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);

  always_ff @(posedge user_clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge user_clk) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/native_port_responder.sv
// Block-RAM backed responder for the LiteDRAM native port: strictly in-order commands,
// byte-enabled writes, fixed-latency reads with credit-based backpressure.
module native_port_responder
  import native_port_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int RD_LATENCY = DEF_RD_LATENCY,
  parameter int CMD_DEPTH  = DEF_CMD_DEPTH
) (
  input  logic                    user_clk,
  input  logic                    reset,
  native_port_responder_if.slave  port,
  output logic [15:0]             wr_count,
  output logic [15:0]             rd_count,
  output logic                    err_oob
);

  localparam int RESP_DEPTH = resp_depth(RD_LATENCY);
  localparam int RESP_CNT_W = $clog2(RESP_DEPTH + 1);
  localparam int CMD_CNT_W  = $clog2(CMD_DEPTH + 1);
  localparam int BYTES      = DATA_W / 8;
  localparam int ENTRY_W    = $bits(cmd_entry_t);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];
  logic [DATA_W-1:0] mem_rdata;

  cmd_entry_t           cmd_in;
  cmd_entry_t           cmd_head;
  logic [ENTRY_W-1:0]   cmd_head_bits;
  logic                 cmd_push;
  logic                 cmd_pop;
  logic                 cmd_full;
  logic                 cmd_empty;
  logic [CMD_CNT_W-1:0] cmd_level;
  logic                 unused_cmd_level;

  logic                  head_is_write;
  logic                  head_is_read;
  logic                  wr_commit;
  logic                  rd_dispatch;
  logic                  credit_ok;
  logic [RESP_CNT_W-1:0] in_flight;

  logic                  resp_push;
  logic [DATA_W-1:0]     resp_push_data;
  logic                  resp_pop;
  logic [DATA_W-1:0]     resp_head;
  logic                  resp_full;
  logic                  resp_empty;
  logic [RESP_CNT_W-1:0] resp_level;

  always_comb begin
    cmd_in      = '0;
    cmd_in.we   = port.cmd_we;
    cmd_in.addr = port.cmd_addr[DEPTH_LOG2-1:0];
  end

  assign port.cmd_ready = !cmd_full && !reset;
  assign cmd_push       = port.cmd_valid && port.cmd_ready;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .user_clk  (user_clk),
    .reset     (reset),
    .push      (cmd_push),
    .push_data (cmd_in),
    .pop       (cmd_pop),
    .pop_data  (cmd_head_bits),
    .full      (cmd_full),
    .empty     (cmd_empty),
    .count     (cmd_level)
  );

  assign cmd_head         = cmd_entry_t'(cmd_head_bits);
  assign unused_cmd_level = ^cmd_level;

  // Credit covers every read already dispatched but not yet handed to the consumer.
  assign credit_ok = !resp_full &&
                     ((int'(in_flight) + int'(resp_level)) < RESP_DEPTH);

  assign head_is_write    = !cmd_empty && cmd_head.we;
  assign head_is_read     = !cmd_empty && !cmd_head.we;
  assign port.wdata_ready = head_is_write && !reset;
  assign wr_commit        = port.wdata_valid && port.wdata_ready;
  assign rd_dispatch      = head_is_read && credit_ok && !reset;
  assign cmd_pop          = wr_commit || rd_dispatch;

  always_ff @(posedge user_clk) begin
    if (wr_commit) begin
      for (int i = 0; i < BYTES; i++) begin
        if (port.wdata_we[i]) mem[cmd_head.addr][i*8 +: 8] <= port.wdata_data[i*8 +: 8];
      end
    end
  end

  assign mem_rdata = mem[cmd_head.addr];

  // The first pipeline register doubles as the block-RAM output register.
  generate
    if (RD_LATENCY == 1) begin : g_direct
      assign resp_push      = rd_dispatch;
      assign resp_push_data = mem_rdata;
    end else begin : g_pipe
      localparam int STAGES = RD_LATENCY - 1;
      logic [STAGES-1:0] pipe_valid;
      logic [DATA_W-1:0] pipe_data [STAGES];

      always_ff @(posedge user_clk) begin
        if (reset) begin
          pipe_valid <= '0;
        end else begin
          pipe_valid[0] <= rd_dispatch;
          for (int s = 1; s < STAGES; s++) pipe_valid[s] <= pipe_valid[s-1];
        end
      end

      always_ff @(posedge user_clk) begin
        if (rd_dispatch) pipe_data[0] <= mem_rdata;
        for (int s = 1; s < STAGES; s++) pipe_data[s] <= pipe_data[s-1];
      end

      assign resp_push      = pipe_valid[STAGES-1];
      assign resp_push_data = pipe_data[STAGES-1];
    end
  endgenerate

  always_ff @(posedge user_clk) begin
    if (reset) begin
      in_flight <= '0;
    end else begin
      case ({rd_dispatch, resp_push})
        2'b10:   in_flight <= in_flight + RESP_CNT_W'(1);
        2'b01:   in_flight <= in_flight - RESP_CNT_W'(1);
        default: in_flight <= in_flight;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .user_clk  (user_clk),
    .reset     (reset),
    .push      (resp_push),
    .push_data (resp_push_data),
    .pop       (resp_pop),
    .pop_data  (resp_head),
    .full      (resp_full),
    .empty     (resp_empty),
    .count     (resp_level)
  );

  assign port.rdata_valid = !resp_empty;
  assign port.rdata_data  = resp_empty ? '0 : resp_head;
  assign resp_pop         = port.rdata_valid && port.rdata_ready;

  always_ff @(posedge user_clk) begin
    if (reset) begin
      wr_count <= '0;
      rd_count <= '0;
      err_oob  <= 1'b0;
    end else begin
      if (wr_commit) wr_count <= wr_count + 16'd1;
      if (resp_pop)  rd_count <= rd_count + 16'd1;
      if (cmd_push && |port.cmd_addr[ADDR_W-1:DEPTH_LOG2]) err_oob <= 1'b1;
    end
  end

endmodule

// File: tb/tb_native_port_responder.sv
// Bench for native_port_responder: vector table plus hand-built sequences, read data checked
// through an expected-value queue filled when each read command is accepted.
module tb_native_port_responder;
  import native_port_pkg::*;

  localparam int ADDR_W     = 24;
  localparam int DATA_W     = 256;
  localparam int DEPTH_LOG2 = 10;
  localparam int RD_LATENCY = 4;
  localparam int CMD_DEPTH  = 4;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       be;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] exp;
  } vec_t;

  logic        user_clk = 1'b0;
  logic        reset    = 1'b1;
  logic [15:0] wr_count;
  logic [15:0] rd_count;
  logic        err_oob;

  int vectors     = 0;
  int miscompares = 0;
  int cycle       = 0;
  int exp_wr      = 0;
  int exp_rd      = 0;
  logic [DATA_W-1:0] exp_q [$];
  vec_t vecs [$];

  native_port_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) port ();

  native_port_responder #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2),
    .RD_LATENCY (RD_LATENCY),
    .CMD_DEPTH  (CMD_DEPTH)
  ) dut (
    .user_clk (user_clk),
    .reset    (reset),
    .port     (port),
    .wr_count (wr_count),
    .rd_count (rd_count),
    .err_oob  (err_oob)
  );

  always #5 user_clk = ~user_clk;
  always @(posedge user_clk) cycle <= cycle + 1;

  task automatic check_output(input string name, input logic [DATA_W-1:0] act,
                              input logic [DATA_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: got timeout expected handshake", name);
  endtask

  // Scoreboard: every delivered beat must match the oldest outstanding expectation.
  always @(negedge user_clk) begin
    if (!reset && port.rdata_valid && port.rdata_ready) begin
      exp_rd++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL rdata_unexpected: got %h expected no beat", port.rdata_data);
      end else begin
        check_output("rdata", port.rdata_data, exp_q.pop_front());
      end
    end
  end

  task automatic send_cmd(input logic we, input logic [ADDR_W-1:0] addr, output int acc_cycle);
    bit acc = 0;
    acc_cycle = -1;
    port.cmd_we    = we;
    port.cmd_addr  = addr;
    port.cmd_valid = 1'b1;
    for (int t = 0; t < 60 && !acc; t++) begin
      @(negedge user_clk);
      acc = port.cmd_ready;
      if (acc) acc_cycle = cycle;
      @(posedge user_clk); #1;
    end
    port.cmd_valid = 1'b0;
    if (!acc) timeout("cmd_accept");
  endtask

  task automatic send_read(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] exp,
                           output int acc_cycle);
    send_cmd(1'b0, addr, acc_cycle);
    if (acc_cycle >= 0) exp_q.push_back(exp);
  endtask

  task automatic push_wdata(input logic [31:0] be, input logic [DATA_W-1:0] data, output int w_cyc);
    bit acc = 0;
    w_cyc = -1;
    port.wdata_we    = be;
    port.wdata_data  = data;
    port.wdata_valid = 1'b1;
    for (int t = 0; t < 60 && !acc; t++) begin
      @(negedge user_clk);
      acc = port.wdata_ready;
      if (acc) w_cyc = cycle;
      @(posedge user_clk); #1;
    end
    port.wdata_valid = 1'b0;
    if (acc) exp_wr++;
    else timeout("wdata_accept");
  endtask

  // Command and data offered together, as the initiator's SENDCMD/WRWAIT path does.
  task automatic send_write(input logic [ADDR_W-1:0] addr, input logic [31:0] be,
                            input logic [DATA_W-1:0] data, output int c_cyc, output int w_cyc);
    bit c_acc, w_acc;
    c_cyc = -1;
    w_cyc = -1;
    port.cmd_we      = 1'b1;
    port.cmd_addr    = addr;
    port.wdata_we    = be;
    port.wdata_data  = data;
    port.cmd_valid   = 1'b1;
    port.wdata_valid = 1'b1;
    for (int t = 0; t < 60 && (port.cmd_valid || port.wdata_valid); t++) begin
      @(negedge user_clk);
      c_acc = port.cmd_valid && port.cmd_ready;
      w_acc = port.wdata_valid && port.wdata_ready;
      if (c_acc) c_cyc = cycle;
      if (w_acc) w_cyc = cycle;
      @(posedge user_clk); #1;
      if (c_acc) port.cmd_valid = 1'b0;
      if (w_acc) begin
        port.wdata_valid = 1'b0;
        exp_wr++;
      end
    end
    if (port.cmd_valid || port.wdata_valid) begin
      port.cmd_valid   = 1'b0;
      port.wdata_valid = 1'b0;
      timeout("write_accept");
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && exp_q.size() != 0; t++) @(posedge user_clk);
    if (exp_q.size() != 0) begin
      timeout("drain");
      exp_q.delete();
    end
    @(posedge user_clk); #1;
  endtask

  task automatic apply_vector(input vec_t v);
    int c, w;
    if (v.we) send_write(v.addr, v.be, v.data, c, w);
    else      send_read(v.addr, v.exp, c);
  endtask

  function automatic vec_t mk(input logic we, input logic [ADDR_W-1:0] addr, input logic [31:0] be,
                              input logic [DATA_W-1:0] data, input logic [DATA_W-1:0] exp);
    vec_t v;
    v.we = we; v.addr = addr; v.be = be; v.data = data; v.exp = exp;
    return v;
  endfunction

  initial begin
    int c, w, seen;
    logic [7:0] b;

    port.cmd_valid   = 1'b0;
    port.cmd_we      = 1'b0;
    port.cmd_addr    = '0;
    port.wdata_valid = 1'b0;
    port.wdata_we    = '0;
    port.wdata_data  = '0;
    port.rdata_ready = 1'b1;

    vecs.push_back(mk(1, 24'h10,  32'hFFFF_FFFF, {32{8'h55}}, '0));
    vecs.push_back(mk(1, 24'h10,  32'h0000_0001, {{31{8'hEE}}, 8'hAB}, '0));
    vecs.push_back(mk(0, 24'h10,  '0, '0, {{31{8'h55}}, 8'hAB}));
    vecs.push_back(mk(1, 24'h3FF, 32'hFFFF_FFFF, {8{32'hDEADBEEF}}, '0));
    vecs.push_back(mk(1, 24'h10,  32'h8000_0000, {8'hC3, {31{8'h00}}}, '0));
    vecs.push_back(mk(0, 24'h3FF, '0, '0, {8{32'hDEADBEEF}}));
    vecs.push_back(mk(0, 24'h10,  '0, '0, {8'hC3, {30{8'h55}}, 8'hAB}));
    vecs.push_back(mk(1, 24'h3FF, 32'h0000_FF00, {32{8'h77}}, '0));
    vecs.push_back(mk(0, 24'h3FF, '0, '0,
                      {{4{32'hDEADBEEF}}, {2{32'h77777777}}, {2{32'hDEADBEEF}}}));
    vecs.push_back(mk(0, 24'h400, '0, '0, {64{4'h1}}));

    // Reset state.
    repeat (3) @(posedge user_clk);
    @(negedge user_clk);
    check_output("reset_cmd_ready",   DATA_W'(port.cmd_ready),   '0);
    check_output("reset_wdata_ready", DATA_W'(port.wdata_ready), '0);
    check_output("reset_rdata_valid", DATA_W'(port.rdata_valid), '0);
    check_output("reset_rdata_data",  port.rdata_data,           '0);
    @(posedge user_clk); #1;
    reset = 1'b0;
    @(negedge user_clk);
    check_output("cmd_ready_after_reset", DATA_W'(port.cmd_ready), DATA_W'(1));
    check_output("wr_count_reset", DATA_W'(wr_count), '0);
    check_output("rd_count_reset", DATA_W'(rd_count), '0);
    check_output("err_oob_reset",  DATA_W'(err_oob),  '0);
    @(posedge user_clk); #1;

    // Full-word write with data alongside, then timed read-back.
    send_write(24'h000400, 32'hFFFF_FFFF, {64{4'h1}}, c, w);
    check_output("wdata_ready_delay", DATA_W'(w - c), DATA_W'(1));
    @(negedge user_clk);
    check_output("wr_count_first", DATA_W'(wr_count), DATA_W'(1));
    @(posedge user_clk); #1;
    send_read(24'h000400, {64{4'h1}}, c);
    seen = -1;
    for (int t = 0; t < 40 && seen < 0; t++) begin
      @(negedge user_clk);
      if (port.rdata_valid) seen = cycle;
    end
    check_output("read_latency", DATA_W'(seen - c), DATA_W'(RD_LATENCY + 1));
    drain();

    // Vector table.
    for (int i = 0; i < vecs.size(); i++) apply_vector(vecs[i]);
    drain();

    // Read queued directly behind a write still waiting for its data.
    send_cmd(1'b1, 24'h20, c);
    send_read(24'h20, {32{8'h3C}}, c);
    push_wdata(32'hFFFF_FFFF, {32{8'h3C}}, w);
    drain();

    // Backpressure: credit admits RESP_DEPTH reads, the command FIFO absorbs CMD_DEPTH more.
    for (int i = 0; i < 10; i++) begin
      b = 8'(8'h10 + i);
      send_write(24'h100 + 24'(i), 32'hFFFF_FFFF, {32{b}}, c, w);
    end
    port.rdata_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      b = 8'(8'h10 + i);
      send_read(24'h100 + 24'(i), {32{b}}, c);
    end
    repeat (5) @(posedge user_clk);
    @(negedge user_clk);
    check_output("stall_cmd_ready",   DATA_W'(port.cmd_ready),   '0);
    check_output("stall_rdata_valid", DATA_W'(port.rdata_valid), DATA_W'(1));
    check_output("stall_rd_count",    DATA_W'(rd_count),         DATA_W'(exp_rd));
    @(posedge user_clk); #1;
    port.rdata_ready = 1'b1;
    drain();
    check_output("rd_count_after_drain", DATA_W'(rd_count), DATA_W'(exp_rd));
    check_output("wr_count_total",       DATA_W'(wr_count), DATA_W'(exp_wr));

    // Out-of-range address aliases onto the low bits and sets the sticky flag.
    send_write(24'h001005, 32'hFFFF_FFFF, {8{32'hCAFEF00D}}, c, w);
    @(negedge user_clk);
    check_output("err_oob_set", DATA_W'(err_oob), DATA_W'(1));
    @(posedge user_clk); #1;
    send_read(24'h000005, {8{32'hCAFEF00D}}, c);
    drain();
    repeat (3) @(posedge user_clk);
    @(negedge user_clk);
    check_output("err_oob_sticky", DATA_W'(err_oob), DATA_W'(1));
    @(posedge user_clk); #1;

    // Reset with reads in flight and a write whose data arrives in the reset cycle.
    port.rdata_ready = 1'b0;
    send_read(24'h10,  '0, c);
    send_read(24'h3FF, '0, c);
    send_read(24'h400, '0, c);
    send_cmd(1'b1, 24'h10, c);
    seen = 0;
    for (int t = 0; t < 40 && seen == 0; t++) begin
      @(negedge user_clk);
      if (port.wdata_ready) seen = 1;
    end
    if (seen == 0) timeout("write_head");
    @(posedge user_clk); #1;
    reset            = 1'b1;
    port.wdata_we    = 32'hFFFF_FFFF;
    port.wdata_data  = {32{8'h99}};
    port.wdata_valid = 1'b1;
    exp_q.delete();
    exp_rd = 0;
    exp_wr = 0;
    @(posedge user_clk); #1;
    port.wdata_valid = 1'b0;
    @(negedge user_clk);
    check_output("rst_rdata_valid", DATA_W'(port.rdata_valid), '0);
    check_output("rst_wdata_ready", DATA_W'(port.wdata_ready), '0);
    check_output("rst_wr_count",    DATA_W'(wr_count),         '0);
    check_output("rst_rd_count",    DATA_W'(rd_count),         '0);
    check_output("rst_err_oob",     DATA_W'(err_oob),          '0);
    @(posedge user_clk); #1;
    reset = 1'b0;
    port.rdata_ready = 1'b1;
    @(negedge user_clk);
    check_output("rst_cmd_ready", DATA_W'(port.cmd_ready), DATA_W'(1));
    @(posedge user_clk); #1;
    send_read(24'h10, {8'hC3, {30{8'h55}}, 8'hAB}, c);
    drain();
    check_output("rst_rd_count_after", DATA_W'(rd_count), DATA_W'(1));

    // Write data ahead of any command is held off until its command is queued.
    port.wdata_we    = 32'hFFFF_FFFF;
    port.wdata_data  = {32{8'h5A}};
    port.wdata_valid = 1'b1;
    for (int t = 0; t < 10; t++) begin
      @(negedge user_clk);
      check_output("early_wdata_ready", DATA_W'(port.wdata_ready), '0);
    end
    check_output("early_wr_count", DATA_W'(wr_count), DATA_W'(exp_wr));
    @(posedge user_clk); #1;
    send_cmd(1'b1, 24'h30, c);
    @(negedge user_clk);
    check_output("early_commit_ready", DATA_W'(port.wdata_ready), DATA_W'(1));
    check_output("early_commit_cycle", DATA_W'(cycle - c), DATA_W'(1));
    @(posedge user_clk); #1;
    port.wdata_valid = 1'b0;
    exp_wr++;
    @(negedge user_clk);
    check_output("early_wr_count_after", DATA_W'(wr_count), DATA_W'(exp_wr));
    @(posedge user_clk); #1;
    send_read(24'h30, {32{8'h5A}}, c);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got no completion expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
